// File: rtl/fsmc_pkg.sv
// Shared types and constants for the FSMC to SDRAM request bridge.
// State encoding, timeout read pattern and default widths.
package fsmc_pkg;

  localparam int DATA_W      = 16;
  localparam int ADDR_W_DEF  = 22;
  localparam int SYNC_DEF    = 2;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [DATA_W-1:0] TMO_PATTERN = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CAPT,
    ST_WR_REQ,
    ST_RD_REQ,
    ST_RD_HOLD,
    ST_WAIT_REL
  } fsmc_state_e;

  function automatic logic [1:0] lane_en(
    input logic nbl1,
    input logic nbl0
  );
    return {~nbl1, ~nbl0};
  endfunction

endpackage

// File: rtl/fsmc_sync.sv
// Multi-flop synchroniser for asynchronous FSMC pin groups.
// Reset loads a per-instance idle value; depth is at least two.
module fsmc_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [W-1:0] ff [N];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) ff[i] <= RST_VAL;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < N; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/fsmc_sdram_bridge.sv
// FSMC async SRAM-style slave to single-word SDRAM request bridge.
// Define FSMC_NWAIT_EN to add the active-low fsmc_nwait output.
module fsmc_sdram_bridge
  import fsmc_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       fsmc_a,
  inout  wire  [15:0]       fsmc_d,
  input  logic              fsmc_ne1,
  input  logic              fsmc_nwe,
  input  logic              fsmc_noe,
  input  logic              fsmc_nbl1,
  input  logic              fsmc_nbl0,
`ifdef FSMC_NWAIT_EN
  output logic              fsmc_nwait,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [1:0]        mem_be,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fsmc_state_e state, state_n;

  logic [4:0]  strb_s;
  logic [31:0] bus_s;
  logic        ne1_s, nwe_s, noe_s;
  logic        nbl1_s, nbl0_s;
  logic [15:0] a_s, d_s;

  logic [15:0]       cap_addr, cap_data;
  logic [1:0]        cap_be;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_abort;
  logic [CNT_W-1:0]  cnt;

  logic req_st, tmo, req_done;
  logic wr_go, rd_go, cap_en;
  logic drive;

  fsmc_sync #(
    .W       (5),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (5'b11111)
  ) u_sync_strb (
    .clk (clk),
    .rst (rst),
    .d   ({fsmc_ne1, fsmc_nwe, fsmc_noe,
           fsmc_nbl1, fsmc_nbl0}),
    .q   (strb_s)
  );

  fsmc_sync #(
    .W       (32),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (32'h0)
  ) u_sync_bus (
    .clk (clk),
    .rst (rst),
    .d   ({fsmc_a, fsmc_d}),
    .q   (bus_s)
  );

  assign {ne1_s, nwe_s, noe_s,
          nbl1_s, nbl0_s} = strb_s;
  assign {a_s, d_s} = bus_s;

  assign req_st = (state == ST_WR_REQ) ||
                  (state == ST_RD_REQ);
  // ack wins over a timeout landing in the same cycle
  assign tmo = req_st && !mem_ack &&
               (cnt == CNT_W'(TIMEOUT - 1));
  assign req_done = req_st && (mem_ack || tmo);

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (!ne1_s && !nwe_s)
          state_n = ST_WR_CAPT;
        else if (!ne1_s && !noe_s)
          state_n = ST_RD_REQ;
      end
      ST_WR_CAPT: begin
        if (nwe_s || ne1_s)
          state_n = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        if (req_done)
          state_n = ST_WAIT_REL;
      end
      ST_RD_REQ: begin
        if (req_done)
          state_n = (rd_abort || ne1_s) ? ST_IDLE
                                        : ST_RD_HOLD;
      end
      ST_RD_HOLD: begin
        if (ne1_s || noe_s)
          state_n = ST_WAIT_REL;
      end
      ST_WAIT_REL: begin
        if (ne1_s)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign wr_go  = (state == ST_WR_CAPT) &&
                  (state_n == ST_WR_REQ);
  assign rd_go  = (state == ST_IDLE) &&
                  (state_n == ST_RD_REQ);
  assign cap_en = (state_n == ST_WR_CAPT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_be    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      err       <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_abort  <= 1'b0;
      cnt       <= '0;
    end else begin
      if (cap_en) begin
        cap_addr <= a_s;
        cap_data <= d_s;
        cap_be   <= lane_en(nbl1_s, nbl0_s);
      end
      if (wr_go) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= ADDR_W'(cap_addr);
        mem_wdata <= cap_data;
        mem_be    <= cap_be;
      end
      if (rd_go) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= ADDR_W'(a_s);
        mem_be   <= 2'b11;
      end
      if (req_done) mem_req <= 1'b0;
      if (tmo)      err     <= 1'b1;
      if ((state == ST_RD_REQ) &&
          (state_n == ST_RD_HOLD)) begin
        rd_data  <= mem_ack ? mem_rdata : TMO_PATTERN;
        rd_valid <= 1'b1;
      end
      if ((state == ST_RD_HOLD) &&
          (state_n == ST_WAIT_REL))
        rd_valid <= 1'b0;
      // remembers a chip-select release seen while the read is pending
      rd_abort <= (state == ST_RD_REQ) &&
                  (state_n == ST_RD_REQ) &&
                  (rd_abort || ne1_s);
      cnt <= (req_st && (state_n == state))
             ? cnt + 1'b1 : '0;
    end
  end

  assign drive = (state == ST_RD_HOLD) && rd_valid &&
                 !ne1_s && !noe_s;
  assign fsmc_d = drive ? rd_data : 16'hzzzz;

`ifdef FSMC_NWAIT_EN
  assign fsmc_nwait = !req_st;
`endif

endmodule

// File: doc/fsmc_sdram_bridge.md
Name: fsmc_sdram_bridge

Overview:
- Slave bridge between the STM32 FSMC asynchronous SRAM-style bus (NE1/NWE/NOE/NBL, 16-bit A/D) and the synchronous request/ack port of the SDRAM controller.
- Sits between the FSMC pins and the SDRAM controller inside the system top level.
- Synchronises all FSMC inputs, turns each chip-select cycle into exactly one single-word SDRAM request, and returns read data on the shared data bus.

Parameters:
- ADDR_W, 22, width of the SDRAM word address; fsmc_a is zero-extended to this width.
- SYNC_STAGES, 2, flop stages on every FSMC input (minimum 2).
- TIMEOUT, 255, cycles to wait for mem_ack before aborting a request.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- fsmc_a  in  16  FSMC halfword address
- fsmc_d  inout  16  FSMC data; driven only as defined under Behaviour, else high-Z
- fsmc_ne1  in  1  chip select, active-low
- fsmc_nwe  in  1  write strobe, active-low
- fsmc_noe  in  1  output enable, active-low
- fsmc_nbl1  in  1  upper byte lane enable, active-low
- fsmc_nbl0  in  1  lower byte lane enable, active-low
- mem_req  out  1  request to SDRAM controller
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  16  write data
- mem_be  out  2  byte enables, active-high ({~nbl1, ~nbl0})
- mem_ack  in  1  one-cycle accept/complete; carries mem_rdata on reads
- mem_rdata  in  16  read data, valid with mem_ack on a read
- err  out  1  sticky timeout flag, cleared only by reset

Behaviour:
- Reset (rst=0 at a clk edge):
  - State IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, err=0.
  - fsmc_d high-Z; read-data register cleared; synchroniser flops loaded with idle values (strobes 1, bus 0).
- Synchronisation:
  - All FSMC inputs pass through SYNC_STAGES flops.
  - Every decision below uses synchronised values (suffix _s).
- States:
  - IDLE:
    - ne1_s=0 and nwe_s=0 -> WR_CAPT.
    - ne1_s=0 and noe_s=0 -> RD_REQ.
    - If both strobes are low, write wins.
  - WR_CAPT:
    - Every cycle, register a_s, d_s and byte enables.
    - When nwe_s or ne1_s returns to 1, the values registered on the previous cycle are committed -> WR_REQ.
  - WR_REQ:
    - mem_req=1, mem_we=1 with the committed addr/data/be.
    - On mem_ack -> WAIT_REL.
  - RD_REQ:
    - mem_req=1, mem_we=0, mem_addr=a_s, mem_be=2'b11.
    - On mem_ack, latch mem_rdata into rd_data and set rd_valid -> RD_HOLD.
  - RD_HOLD:
    - fsmc_d = rd_data while ne1_s=0 and noe_s=0 and rd_valid=1.
    - When ne1_s or noe_s returns to 1, release the bus and clear rd_valid -> WAIT_REL.
  - WAIT_REL:
    - Stay until ne1_s=1, then -> IDLE.
    - Guarantees one SDRAM access per chip-select cycle.
- Request handshake:
  - mem_req and its qualifiers are held stable from assertion until and including the mem_ack cycle.
  - mem_req deasserts the cycle after mem_ack.
  - mem_ack while mem_req=0 is ignored.
- Read aborted early (ne1_s rises before mem_ack in RD_REQ):
  - Request stays asserted until mem_ack; the data is discarded, the bus is never driven, then -> IDLE.
- Timeout:
  - A counter runs in WR_REQ/RD_REQ and resets on every state entry.
  - If it reaches TIMEOUT without mem_ack: drop mem_req and set err=1.
  - A read then presents 16'hDEAD as rd_data (-> RD_HOLD); a write goes -> WAIT_REL.
- Latency: a read's data is available on the bus no earlier than SYNC_STAGES+2 cycles after NOE falls, plus the controller's ack latency.
- Reset mid-transaction: returns to IDLE immediately and releases the bus; any outstanding controller request is dropped.

Optional Feature:
- Macro FSMC_NWAIT_EN.
- Defined:
  - Adds output port fsmc_nwait (1 bit, active-low, reset value 1).
  - fsmc_nwait=0 from the cycle the FSM leaves IDLE for a read until rd_valid=1.
  - For writes it is 0 throughout WR_REQ.
  - The FSMC can then run with the wait signal enabled instead of fixed long DATAST timings.
- Not defined: the port is absent; the host must use worst-case fixed timings.

Decomposition:
- Package fsmc_pkg:
  - State encoding typedef (IDLE, WR_CAPT, WR_REQ, RD_REQ, RD_HOLD, WAIT_REL).
  - Timeout pattern constant 16'hDEAD.
  - Default widths.
- One sub-module, fsmc_sync: a parameterised SYNC_STAGES-deep synchroniser, instantiated for the strobe and bus vectors.

Test Plan:
- Write, 16-bit: ne1=0, nwe=0, a=16'hAAAA, d=16'hBBBB held 50 us, then released -> exactly one mem_req with mem_we=1, mem_addr=22'h00AAAA, mem_wdata=16'hBBBB, mem_be=2'b11; no further request.
- Second write, then read-back: write 16'hDDDD to 16'hCCCC, then ne1=0, noe=0, a=16'hAAAA -> one read request to 22'h00AAAA; fsmc_d=16'hBBBB while noe low; high-Z within SYNC_STAGES+1 cycles of release.
- Byte write: nbl1=1, nbl0=0, d=16'h1234 -> mem_be=2'b01.
- Controller stalls mem_ack for 10 cycles -> mem_req and all qualifiers stable through the ack cycle; mem_req low the next cycle.
- No mem_ack on a read -> mem_req drops after TIMEOUT cycles, err=1, fsmc_d=16'hDEAD.
- Read aborted before ack, then rst=0 asserted mid-write -> no bus drive on the aborted read; all outputs return to reset values on the next clk edge.
